// File: rtl/rv32i_types.sv
// Shared RV32I core types: arbiter states, grant side and the cache-line word.
package rv32i_types;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum bit {GNT_I, GNT_D} arb_grant_t;
    typedef logic [255:0] rv32i_line;

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side signals of the cache arbiter grouped as one bundle.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [CNT_W-1:0]  conflict_cnt;

    // Arbiter view
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, conflict_cnt
    );

    // Environment view: caches plus physical memory
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, conflict_cnt
    );
endinterface

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating event counter; shared by the conflict counter and other perf counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical-memory port between I-cache and D-cache, one line transaction
// at a time, alternating the grant on simultaneous requests.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input logic             clk,
    input logic             rst,
    cache_arbiter_if.slave  bus
);
    arb_state_t       state_q, state_d;
    arb_grant_t       last_grant_q, last_grant_d;
    logic             conflict_inc;
    logic [CNT_W-1:0] cnt;
    logic             i_req, d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        conflict_inc    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.pmem_addr   = bus.d_addr;
        bus.pmem_wdata  = bus.d_wdata;
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        // Non-granted side still sees live memory data so rdata is never X
        bus.i_rdata     = bus.pmem_rdata;
        bus.d_rdata     = bus.pmem_rdata;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    conflict_inc = 1'b1;
                    if (last_grant_q == GNT_I) begin
                        state_d      = SERVE_D;
                        last_grant_d = GNT_D;
                    end else begin
                        state_d      = SERVE_I;
                        last_grant_d = GNT_I;
                    end
                end else if (i_req) begin
                    state_d      = SERVE_I;
                    last_grant_d = GNT_I;
                end else if (d_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = GNT_D;
                end
            end
            SERVE_I: begin
                bus.pmem_addr  = bus.i_addr;
                bus.pmem_wdata = '0;
                bus.pmem_read  = bus.i_read;
                if (bus.pmem_resp) begin
                    bus.i_resp = 1'b1;
                    state_d    = IDLE;
                end
            end
            SERVE_D: begin
                bus.pmem_read  = bus.d_read;
                bus.pmem_write = bus.d_write;
                if (bus.pmem_resp) begin
                    bus.d_resp = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict_inc),
        .count (cnt)
    );

    assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-side transactions, conflict alternation,
// mid-transaction reset and counter saturation on a narrow-counter instance.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    cache_arbiter_if              ifc ();
    cache_arbiter_if #(.CNT_W(4)) ifc4 ();

    cache_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    cache_arbiter #(.CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifc4.slave)
    );

    logic [255:0] pat_a5;
    logic [255:0] pat_12;
    logic [255:0] pat_3c;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        ifc.i_read = 0; ifc.i_addr = '0; ifc.d_read = 0; ifc.d_write = 0;
        ifc.d_addr = '0; ifc.d_wdata = '0; ifc.pmem_rdata = '0; ifc.pmem_resp = 0;
        ifc4.i_read = 0; ifc4.i_addr = '0; ifc4.d_read = 0; ifc4.d_write = 0;
        ifc4.d_addr = '0; ifc4.d_wdata = '0; ifc4.pmem_rdata = '0; ifc4.pmem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(); cyc();
        rst = 0;
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_12 = {8{32'h1234_5678}};
        pat_3c = {32{8'h3C}};
        clr_inputs();
        do_reset();
        #1;
        chk("rst_cnt",   ifc.conflict_cnt, 0);
        chk("rst_rd",    ifc.pmem_read,  0);
        chk("rst_wr",    ifc.pmem_write, 0);
        chk("rst_iresp", ifc.i_resp, 0);
        chk("rst_dresp", ifc.d_resp, 0);

        // 1: I-only read
        ifc.i_read = 1; ifc.i_addr = 32'h0000_0040;
        #1 chk("t1_idle_rd", ifc.pmem_read, 0);
        cyc();
        chk("t1_rd",   ifc.pmem_read, 1);
        chk("t1_addr", ifc.pmem_addr, 32'h40);
        chk("t1_wr",   ifc.pmem_write, 0);
        cyc(); cyc();
        chk("t1_wait_iresp", ifc.i_resp, 0);
        ifc.pmem_rdata = pat_a5; ifc.pmem_resp = 1;
        #1;
        chk("t1_iresp", ifc.i_resp, 1);
        chk("t1_irdata", ifc.i_rdata, pat_a5);
        chk("t1_dresp", ifc.d_resp, 0);
        cyc();
        ifc.i_read = 0; ifc.pmem_resp = 0;
        #1;
        chk("t1_iresp_end", ifc.i_resp, 0);
        chk("t1_rd_end", ifc.pmem_read, 0);

        // 2: D-only write
        ifc.d_write = 1; ifc.d_addr = 32'h80; ifc.d_wdata = pat_12;
        cyc();
        chk("t2_wr",    ifc.pmem_write, 1);
        chk("t2_rd",    ifc.pmem_read, 0);
        chk("t2_addr",  ifc.pmem_addr, 32'h80);
        chk("t2_wdata", ifc.pmem_wdata, pat_12);
        cyc();
        ifc.pmem_resp = 1;
        #1;
        chk("t2_dresp", ifc.d_resp, 1);
        chk("t2_iresp", ifc.i_resp, 0);
        cyc();
        ifc.d_write = 0; ifc.pmem_resp = 0;
        #1;
        chk("t2_dresp_end", ifc.d_resp, 0);
        chk("t2_wr_idle",   ifc.pmem_write, 0);
        chk("t2_cnt",       ifc.conflict_cnt, 0);

        // 3: conflict right after reset goes to D
        clr_inputs();
        do_reset();
        ifc.i_read = 1; ifc.i_addr = 32'h100;
        ifc.d_read = 1; ifc.d_addr = 32'h200;
        cyc();
        chk("t3_d_addr", ifc.pmem_addr, 32'h200);
        chk("t3_d_rd",   ifc.pmem_read, 1);
        chk("t3_cnt",    ifc.conflict_cnt, 1);
        ifc.pmem_rdata = pat_3c; ifc.pmem_resp = 1;
        #1;
        chk("t3_dresp", ifc.d_resp, 1);
        chk("t3_drdata", ifc.d_rdata, pat_3c);
        chk("t3_iresp0", ifc.i_resp, 0);
        cyc();
        ifc.d_read = 0; ifc.d_addr = 32'h300; ifc.pmem_resp = 0;
        #1;
        chk("t3_dead_rd",   ifc.pmem_read, 0);
        chk("t3_dead_addr", ifc.pmem_addr, 32'h300);
        cyc();
        chk("t3_i_addr", ifc.pmem_addr, 32'h100);
        chk("t3_i_rd",   ifc.pmem_read, 1);
        chk("t3_cnt_i",  ifc.conflict_cnt, 1);
        ifc.pmem_resp = 1;
        #1 chk("t3_iresp", ifc.i_resp, 1);
        cyc();
        ifc.i_read = 0; ifc.pmem_resp = 0;

        // D-only read so the last grant is D before the next conflict
        ifc.d_read = 1; ifc.d_addr = 32'h400;
        cyc();
        ifc.pmem_resp = 1;
        #1 chk("t4_pre_dresp", ifc.d_resp, 1);
        cyc();
        ifc.d_read = 0; ifc.pmem_resp = 0;

        // 4: conflict alternates to I
        ifc.i_read = 1; ifc.i_addr = 32'h500;
        ifc.d_read = 1; ifc.d_addr = 32'h600;
        cyc();
        chk("t4_i_addr", ifc.pmem_addr, 32'h500);
        chk("t4_cnt",    ifc.conflict_cnt, 2);
        ifc.pmem_resp = 1;
        #1;
        chk("t4_iresp", ifc.i_resp, 1);
        chk("t4_dresp", ifc.d_resp, 0);
        cyc();
        ifc.i_read = 0; ifc.pmem_resp = 0;
        cyc();
        chk("t4_d_after", ifc.pmem_addr, 32'h600);
        ifc.pmem_resp = 1;
        #1 chk("t4_dresp2", ifc.d_resp, 1);
        cyc();
        clr_inputs();

        // 5: reset during SERVE_D
        do_reset();
        ifc.i_read = 1; ifc.i_addr = 32'h700;
        ifc.d_read = 1; ifc.d_addr = 32'h800;
        cyc();
        chk("t5_serve_d", ifc.pmem_addr, 32'h800);
        chk("t5_cnt1",    ifc.conflict_cnt, 1);
        rst = 1;
        cyc();
        chk("t5_rd",    ifc.pmem_read, 0);
        chk("t5_wr",    ifc.pmem_write, 0);
        chk("t5_cnt0",  ifc.conflict_cnt, 0);
        chk("t5_dresp", ifc.d_resp, 0);
        rst = 0;
        ifc.i_read = 0; ifc.d_read = 0;
        ifc.pmem_resp = 1;
        #1;
        chk("t5_stray_d", ifc.d_resp, 0);
        chk("t5_stray_i", ifc.i_resp, 0);
        cyc();
        ifc.pmem_resp = 0;
        #1;
        chk("t5_idle_rd", ifc.pmem_read, 0);
        chk("t5_idle_cnt", ifc.conflict_cnt, 0);

        // 6: narrow counter saturates
        for (int k = 0; k < 20; k++) begin
            ifc4.i_read = 1; ifc4.i_addr = 32'h10;
            ifc4.d_read = 1; ifc4.d_addr = 32'h20;
            cyc();
            if (k == 0) chk("t6_first_d", ifc4.pmem_addr, 32'h20);
            if (k == 1) chk("t6_second_i", ifc4.pmem_addr, 32'h10);
            if (k == 13) chk("t6_cnt14", ifc4.conflict_cnt, 4'hE);
            ifc4.pmem_resp = 1;
            cyc();
            ifc4.i_read = 0; ifc4.d_read = 0; ifc4.pmem_resp = 0;
            cyc();
        end
        chk("t6_sat", ifc4.conflict_cnt, 4'hF);
        chk("t6_main_cnt", ifc.conflict_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
